// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts word/byte load/store requests, inserts
// WAIT_STATES wait cycles, performs the access on an internal word array.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 7,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_byte,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error
);

    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);
    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        cnt;
    logic                    lat_write, lat_byte;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [31:0]             lat_wdata;
    logic [31:0]             mem [DEPTH];

    logic [ADDR_WIDTH-3:0]   word_idx;
    logic [1:0]              lane;
    logic [31:0]             cur_word, merged_word, mem_wdata, access_rdata;
    logic                    access_error, mem_we;

    assign word_idx  = lat_addr[ADDR_WIDTH-1:2];
    assign lane      = lat_addr[1:0];
    assign req_ready = (state == S_IDLE);

    // Access datapath; byte stores are a read-modify-write of the addressed word
    always_comb begin
        cur_word     = mem[word_idx];
        access_error = !lat_byte && (lane != 2'd0);
        merged_word  = cur_word;
        merged_word[{lane, 3'b000} +: 8] = lat_wdata[7:0];
        mem_wdata    = lat_byte ? merged_word : lat_wdata;
        mem_we       = (state == S_ACCESS) && lat_write && !access_error;
        access_rdata = '0;
        if (!lat_write && !access_error)
            access_rdata = lat_byte ? {24'b0, cur_word[{lane, 3'b000} +: 8]} : cur_word;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (req_valid) state_nx = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
            S_WAIT:   if (cnt == CNT_W'(1)) state_nx = S_ACCESS;
            S_ACCESS: state_nx = S_RESP;
            S_RESP:   if (resp_ready) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            lat_write  <= 1'b0;
            lat_byte   <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    lat_write <= req_write;
                    lat_byte  <= req_byte;
                    lat_addr  <= req_addr;
                    lat_wdata <= req_wdata;
                    cnt       <= CNT_W'(WAIT_STATES);
                end
                S_WAIT: cnt <= cnt - CNT_W'(1);
                S_ACCESS: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= access_rdata;
                    resp_error <= access_error;
                end
                S_RESP: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_error <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Array is never reset; a reset before ACCESS leaves it untouched
    always_ff @(posedge clock) begin
        if (mem_we) mem[word_idx] <= mem_wdata;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder; instance 0 uses
// WAIT_STATES=2, instance 1 uses WAIT_STATES=0, each against an array model.
module tb_data_mem_responder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic        req_byte   [2];
    logic [6:0]  req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_error [2];

    int          ws [2] = '{2, 0};
    logic [31:0] model [2][32];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clock = ~clock;

    data_mem_responder #(.ADDR_WIDTH(7), .WAIT_STATES(2)) dut_ws2 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_byte(req_byte[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0])
    );

    data_mem_responder #(.ADDR_WIDTH(7), .WAIT_STATES(0)) dut_ws0 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_byte(req_byte[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request through instance d, checked against the model; the response
    // is held off for 'hold' cycles, during which a stray req_valid is pulsed.
    task automatic do_req(input int d, input logic wr, input logic by,
                          input logic [6:0] addr, input logic [31:0] wdata, input int hold);
        logic [31:0] exp_rdata, w, mask;
        logic        exp_err;
        int          lane, idx, edges, low;
        bit          seen;
        lane = int'(addr[1:0]);
        idx  = int'(addr[6:2]);
        exp_err   = !by && (lane != 0);
        exp_rdata = 32'h0;
        if (!exp_err) begin
            w = model[d][idx];
            if (wr && by) begin
                mask = 32'hFF << (8 * lane);
                model[d][idx] = (w & ~mask) | ({24'h0, wdata[7:0]} << (8 * lane));
            end else if (wr) begin
                model[d][idx] = wdata;
            end else if (by) begin
                exp_rdata = (w >> (8 * lane)) & 32'hFF;
            end else begin
                exp_rdata = w;
            end
        end

        @(negedge clock);
        check($sformatf("req_ready_idle%0d", d), 32'(req_ready[d]), 32'h1);
        req_valid[d] = 1'b1; req_write[d] = wr; req_byte[d] = by;
        req_addr[d] = addr; req_wdata[d] = wdata;
        @(posedge clock); #1;
        req_valid[d] = 1'b0;
        low = (req_ready[d] == 1'b0) ? 1 : 0;
        if (hold > 0) resp_ready[d] = 1'b0;
        seen = 0;
        edges = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(posedge clock); #1;
            edges = k;
            if (req_ready[d] == 1'b0) low++;
            if (resp_valid[d]) seen = 1;
        end
        if (!seen) begin
            check($sformatf("resp_timeout%0d", d), 32'(resp_valid[d]), 32'h1);
            resp_ready[d] = 1'b1;
            return;
        end
        check($sformatf("latency%0d", d), 32'(edges), 32'(ws[d] + 1));
        check($sformatf("rdata%0d@%h", d, addr), resp_rdata[d], exp_rdata);
        check($sformatf("error%0d@%h", d, addr), 32'(resp_error[d]), 32'(exp_err));
        for (int h = 0; h < hold; h++) begin
            if (h == 1) req_valid[d] = 1'b1;
            if (h == 2) req_valid[d] = 1'b0;
            @(posedge clock); #1;
            if (req_ready[d] == 1'b0) low++;
            check($sformatf("hold_valid%0d", d), 32'(resp_valid[d]), 32'h1);
            check($sformatf("hold_rdata%0d", d), resp_rdata[d], exp_rdata);
            check($sformatf("hold_ready%0d", d), 32'(req_ready[d]), 32'h0);
        end
        req_valid[d] = 1'b0;
        resp_ready[d] = 1'b1;
        @(posedge clock); #1;
        check($sformatf("done_valid%0d", d), 32'(resp_valid[d]), 32'h0);
        check($sformatf("done_error%0d", d), 32'(resp_error[d]), 32'h0);
        check($sformatf("done_ready%0d", d), 32'(req_ready[d]), 32'h1);
        check($sformatf("busy_cycles%0d", d), 32'(low), 32'(ws[d] + 2 + hold));
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; req_byte[d] = 1'b0;
            req_addr[d] = '0; req_wdata[d] = '0; resp_ready[d] = 1'b1;
        end
        repeat (2) @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_req_ready%0d", d), 32'(req_ready[d]), 32'h1);
            check($sformatf("rst_resp_valid%0d", d), 32'(resp_valid[d]), 32'h0);
            check($sformatf("rst_rdata%0d", d), resp_rdata[d], 32'h0);
            check($sformatf("rst_error%0d", d), 32'(resp_error[d]), 32'h0);
        end
        @(negedge clock);
        reset_n = 1'b1;

        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 32; w++)
                do_req(d, 1'b1, 1'b0, 7'(w * 4), $urandom, 0);

        do_req(0, 1'b1, 1'b0, 7'h08, 32'hDEADBEEF, 0);
        do_req(0, 1'b0, 1'b0, 7'h08, 32'h0, 0);
        do_req(0, 1'b1, 1'b0, 7'h0C, 32'h11223344, 0);
        do_req(0, 1'b1, 1'b1, 7'h0D, 32'hFFFFFFAB, 0);
        do_req(0, 1'b0, 1'b0, 7'h0C, 32'h0, 0);
        check("model_merge", model[0][3], 32'h1122AB44);
        do_req(0, 1'b0, 1'b1, 7'h0E, 32'h0, 0);
        do_req(0, 1'b1, 1'b0, 7'h04, 32'h0000CAFE, 0);
        do_req(0, 1'b1, 1'b0, 7'h05, 32'hFFFFFFFF, 0);
        do_req(0, 1'b0, 1'b0, 7'h04, 32'h0, 0);
        do_req(0, 1'b0, 1'b0, 7'h08, 32'h0, 5);

        // Reset while a store to 0x10 sits in WAIT must leave the word at 0
        do_req(0, 1'b1, 1'b0, 7'h10, 32'h0, 0);
        @(negedge clock);
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_byte[0] = 1'b0;
        req_addr[0] = 7'h10; req_wdata[0] = 32'h12345678;
        @(posedge clock); #1;
        req_valid[0] = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        check("abort_req_ready", 32'(req_ready[0]), 32'h1);
        check("abort_resp_valid", 32'(resp_valid[0]), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        do_req(0, 1'b0, 1'b0, 7'h10, 32'h0, 0);

        do_req(1, 1'b1, 1'b0, 7'h20, 32'hA5A5F00D, 0);
        do_req(1, 1'b0, 1'b0, 7'h20, 32'h0, 0);
        do_req(1, 1'b0, 1'b1, 7'h23, 32'h0, 3);

        for (int n = 0; n < 300; n++) begin
            logic [6:0] a;
            int dsel;
            dsel = n % 2;
            a = 7'($urandom);
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            do_req(dsel, 1'($urandom), 1'($urandom), a, $urandom,
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the core's data-memory request interface: accepts word/byte load and store requests from the datapath, inserts programmable wait states, executes the access on an internal word array and returns a handshaked response.
- Sits between the single-cycle core's load/store path and data storage; replaces the zero-latency memory so the core can be exercised against multi-cycle memory.
- Byte-lane write merging (read-modify-write), byte-read zero-extension and misalignment detection are handled inside the block, not in the datapath.

Parameters:
- ADDR_WIDTH, 7, byte-address width; the array holds 2^(ADDR_WIDTH-2) 32-bit words.
- WAIT_STATES, 2, cycles spent in WAIT before the access executes; 0 is legal and skips WAIT.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  a request is presented.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access (sb/lb), 0 = word access (sw/lw).
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data; byte stores use bits [7:0] only.
- resp_valid  out  1  response is available.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  32  load data; 0 for stores and for errors.
- resp_error  out  1  misaligned word access.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, wait counter=0.
  - Array contents are not reset.
  - Reset during WAIT or ACCESS aborts the request; any store not yet committed is never written.
- States: IDLE, WAIT, ACCESS, RESP. req_ready=1 only in IDLE.
- IDLE:
  - On req_valid=1, latch write, byte, addr and wdata.
  - Load the counter with WAIT_STATES and go to WAIT, or go directly to ACCESS when WAIT_STATES=0.
  - With req_valid=0, stay in IDLE.
- WAIT: decrement the counter each cycle; on the cycle the counter equals 1, go to ACCESS. The state lasts exactly WAIT_STATES cycles. req_valid is ignored.
- ACCESS (1 cycle): word index = addr[ADDR_WIDTH-1:2]; lane = addr[1:0], lane 0 = bits [7:0] (little-endian).
  - Word access with lane≠0: no array change, resp_error=1, resp_rdata=0.
  - Word load: resp_rdata = word.
  - Word store: word = wdata; resp_rdata=0.
  - Byte load: resp_rdata = {24'b0, selected lane}.
  - Byte store: write the word back with only the selected lane replaced by wdata[7:0]; the other lanes are preserved. resp_rdata=0.
  - Go to RESP; resp_valid, resp_rdata and resp_error are registered on this edge.
- RESP:
  - resp_valid=1; resp_rdata and resp_error are held stable until resp_ready=1.
  - On the handshake edge: resp_valid=0, resp_error=0, go to IDLE. req_ready is 1 in the following cycle, so there are no back-to-back requests.
- Latency: resp_valid rises WAIT_STATES+1 edges after the acceptance edge. Minimum request-to-request spacing is WAIT_STATES+3 cycles when resp_ready is held at 1.
- Array is written only in ACCESS, at most once per request.

Test Plan:
- WAIT_STATES=2: store word 0xDEADBEEF at 0x08, then load 0x08 -> resp_rdata=0xDEADBEEF, resp_error=0; resp_valid rises 3 edges after each acceptance.
- Byte store 0xAB to 0x0D over word 0x11223344 at 0x0C, then word load 0x0C -> 0x1122AB44; byte load 0x0E -> 0x00000022.
- Word store 0xFFFFFFFF to 0x05 (word at 0x04 = 0x0000CAFE) -> resp_error=1, resp_rdata=0; a later load of 0x04 returns 0x0000CAFE.
- Hold resp_ready=0 for 5 cycles after resp_valid rises -> resp_valid=1 and resp_rdata unchanged throughout, req_ready=0; a req_valid pulse in this window is ignored.
- Assert reset_n=0 during WAIT of a store of 0x12345678 to 0x10 (prior contents 0x0) -> req_ready=1 and resp_valid=0 immediately; a later load of 0x10 returns 0x0.
- WAIT_STATES=0: load -> resp_valid rises 1 edge after acceptance; req_ready is low for exactly 2 cycles with resp_ready=1.
